// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux over enabled channels, settles, captures y and hands it off.
// Define MUX_SCAN_CONT_EN for continuous scanning (only stop ends a pass).
module mux_scan_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] mask,
    input  logic [3:0] dwell,
    input  logic       y,
    input  logic       ready,
    output logic [1:0] s,
    output logic       sample,
    output logic [1:0] ch,
    output logic       valid,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
    state_t state, state_d;
    logic [3:0] mask_q, mask_q_d, dwell_q, dwell_q_d, cnt, cnt_d;
    logic [1:0] s_d, ch_d, first, nxt, s1, s2, s3;
    logic sample_d, valid_d, stop_q, stop_q_d, wrap, done;
    assign busy  = state != IDLE;
    assign first = mask[0] ? 2'd0 : mask[1] ? 2'd1 : mask[2] ? 2'd2 : 2'd3;
    assign s1    = s + 2'd1;
    assign s2    = s + 2'd2;
    assign s3    = s + 2'd3;
    // nearest enabled channel above s, wrapping; a lone channel succeeds itself
    assign nxt   = mask_q[s1] ? s1 : mask_q[s2] ? s2 : mask_q[s3] ? s3 : s;
    assign wrap  = nxt <= s;
`ifdef MUX_SCAN_CONT_EN
    assign done  = stop_q | stop;
`else
    assign done  = stop_q | stop | wrap;
`endif
    always_comb begin
        state_d   = state;
        s_d       = s;
        ch_d      = ch;
        sample_d  = sample;
        valid_d   = valid;
        cnt_d     = cnt;
        mask_q_d  = mask_q;
        dwell_q_d = dwell_q;
        stop_q_d  = stop_q | (stop & busy);
        case (state)
            IDLE: if (start && mask != 4'd0) begin
                mask_q_d  = mask;
                dwell_q_d = dwell;
                s_d       = first;
                cnt_d     = dwell;
                state_d   = SETTLE;
            end
            SETTLE: if (cnt == 4'd0) begin
                sample_d = y;
                ch_d     = s;
                valid_d  = 1'b1;
                state_d  = HOLD;
            end else begin
                cnt_d = cnt - 4'd1;
            end
            HOLD: if (ready) begin
                valid_d = 1'b0;
                if (done) begin
                    state_d  = IDLE;
                    s_d      = 2'd0;
                    stop_q_d = 1'b0;
                end else begin
                    s_d     = nxt;
                    cnt_d   = dwell_q;
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            s       <= 2'd0;
            ch      <= 2'd0;
            sample  <= 1'b0;
            valid   <= 1'b0;
            cnt     <= 4'd0;
            mask_q  <= 4'd0;
            dwell_q <= 4'd0;
            stop_q  <= 1'b0;
        end else begin
            state   <= state_d;
            s       <= s_d;
            ch      <= ch_d;
            sample  <= sample_d;
            valid   <= valid_d;
            cnt     <= cnt_d;
            mask_q  <= mask_q_d;
            dwell_q <= dwell_q_d;
            stop_q  <= stop_q_d;
        end
    end
endmodule
